// File: rtl/multicycle_datapath_if.sv
// rtl/multicycle_datapath_if.sv - instruction/data memory handshake bundle for the multicycle datapath
interface multicycle_datapath_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16
);
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic [15:0]       imem_rdata;
    logic              imem_valid;
    logic              dmem_re;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ready;

    modport master (
        output imem_req, imem_addr, dmem_re, dmem_we, dmem_addr, dmem_wdata,
        input  imem_rdata, imem_valid, dmem_rdata, dmem_ready
    );

    modport slave (
        input  imem_req, imem_addr, dmem_re, dmem_we, dmem_addr, dmem_wdata,
        output imem_rdata, imem_valid, dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/multicycle_datapath.sv
// rtl/multicycle_datapath.sv - 16-bit-encoding multicycle RISC datapath (FETCH/DECODE/EXEC/MEM/WB)
module multicycle_datapath #(
    parameter int              DATA_W   = 16,
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] PC_RESET = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en_i,
    input  logic                 jump_i,
    input  logic                 beq_i,
    input  logic                 bne_i,
    input  logic                 mem_read_i,
    input  logic                 mem_write_i,
    input  logic                 alu_src_i,
    input  logic                 reg_dst_i,
    input  logic                 mem_to_reg_i,
    input  logic                 reg_write_i,
    input  logic [1:0]           alu_op_i,
    output logic [3:0]           opcode_o,
    multicycle_datapath_if.master mem,
    output logic [PC_W-1:0]      pc_out_o,
    output logic [2:0]           state_out_o,
    output logic                 retire_o,
    output logic [31:0]          retire_count_o
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, pc2;
    logic [15:0]       ir_q;
    logic [DATA_W-1:0] a_q, b_q, alu_out_q, mdr_q;
    logic [DATA_W-1:0] gpr_q [8];
    logic [31:0]       retire_count_q;

    logic [DATA_W-1:0] imm_ext, alu_b, alu_res, wb_data;
    logic [PC_W-1:0]   br_off;
    logic [2:0]        alu_fn, wb_idx;
    logic              zero, slt_bit;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  if (en_i && mem.imem_valid) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (mem_read_i || mem_write_i) state_d = S_MEM;
                else if (reg_write_i)          state_d = S_WB;
                else                           state_d = S_FETCH;
            end
            S_MEM:    if (mem.dmem_ready) state_d = reg_write_i ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Every request strobe and the retire pulse are forced low while reset is high.
    always_comb begin
        mem.imem_req = 1'b0;
        mem.dmem_re  = 1'b0;
        mem.dmem_we  = 1'b0;
        retire_o     = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: mem.imem_req = en_i;
                S_MEM: begin
                    mem.dmem_we = mem_write_i;
                    mem.dmem_re = mem_read_i & ~mem_write_i;
                end
                default: ;
            endcase
            retire_o = (state_q != S_FETCH) && (state_d == S_FETCH);
        end
    end

    assign imm_ext = {{(DATA_W-6){ir_q[5]}}, ir_q[5:0]};
    assign alu_b   = alu_src_i ? imm_ext : b_q;
    assign slt_bit = $signed(a_q) < $signed(alu_b);

    always_comb begin
        unique case (alu_op_i)
            2'b10:   alu_fn = 3'd0;
            2'b01:   alu_fn = 3'd1;
            default: alu_fn = ir_q[14:12];
        endcase
    end

    always_comb begin
        alu_res = '0;
        unique case (alu_fn)
            3'd0: alu_res = a_q + alu_b;
            3'd1: alu_res = a_q - alu_b;
            3'd2: alu_res = ~a_q;
            3'd3: alu_res = a_q << alu_b[3:0];
            3'd4: alu_res = a_q >> alu_b[3:0];
            3'd5: alu_res = a_q & alu_b;
            3'd6: alu_res = a_q | alu_b;
            3'd7: alu_res = {{(DATA_W-1){1'b0}}, slt_bit};
            default: alu_res = '0;
        endcase
    end

    assign zero   = (alu_res == '0);
    assign pc2    = pc_q + {{(PC_W-2){1'b0}}, 2'd2};
    assign br_off = {{(PC_W-7){ir_q[5]}}, ir_q[5:0], 1'b0};

    always_comb begin
        if (jump_i)                              pc_d = {pc2[PC_W-1:13], ir_q[11:0], 1'b0};
        else if ((beq_i && zero) || (bne_i && !zero)) pc_d = pc2 + br_off;
        else                                     pc_d = pc2;
    end

    assign wb_idx  = reg_dst_i ? ir_q[5:3] : ir_q[8:6];
    assign wb_data = mem_to_reg_i ? mdr_q : alu_out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q           <= PC_RESET;
            ir_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            alu_out_q      <= '0;
            mdr_q          <= '0;
            retire_count_q <= '0;
            for (int i = 0; i < 8; i++) gpr_q[i] <= '0;
        end else begin
            case (state_q)
                S_FETCH: if (mem.imem_req && mem.imem_valid) ir_q <= mem.imem_rdata;
                S_DECODE: begin
                    a_q <= gpr_q[ir_q[11:9]];
                    b_q <= gpr_q[ir_q[8:6]];
                end
                S_EXEC: begin
                    alu_out_q <= alu_res;
                    pc_q      <= pc_d;
                end
                S_MEM:   if (mem.dmem_ready && mem.dmem_re) mdr_q <= mem.dmem_rdata;
                S_WB:    gpr_q[wb_idx] <= wb_data;
                default: ;
            endcase
            if (retire_o) retire_count_q <= retire_count_q + 32'd1;
        end
    end

    assign mem.imem_addr  = pc_q;
    assign mem.dmem_addr  = alu_out_q;
    assign mem.dmem_wdata = b_q;
    assign opcode_o       = ir_q[15:12];
    assign pc_out_o       = pc_q;
    assign state_out_o    = state_q;
    assign retire_count_o = retire_count_q;
endmodule

// File: tb/tb_multicycle_datapath.sv
// tb/tb_multicycle_datapath.sv - self-checking bench for multicycle_datapath (DATA_W=32, PC_RESET=0xE000)
module tb_multicycle_datapath;
    localparam int          DW  = 32;
    localparam int          PW  = 16;
    localparam logic [15:0] PCR = 16'hE000;
    localparam logic [15:0] NOP = 16'hE000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write;
    logic [1:0]  alu_op;
    logic [3:0]  opcode;
    logic [15:0] pc_out;
    logic [2:0]  state_out;
    logic        retire;
    logic [31:0] retire_count;

    multicycle_datapath_if #(.DATA_W(DW), .PC_W(PW)) bus ();

    multicycle_datapath #(.DATA_W(DW), .PC_W(PW), .PC_RESET(PCR)) dut (
        .clk(clk), .reset(reset), .en_i(en),
        .jump_i(jump), .beq_i(beq), .bne_i(bne), .mem_read_i(mem_read), .mem_write_i(mem_write),
        .alu_src_i(alu_src), .reg_dst_i(reg_dst), .mem_to_reg_i(mem_to_reg), .reg_write_i(reg_write),
        .alu_op_i(alu_op), .opcode_o(opcode), .mem(bus), .pc_out_o(pc_out),
        .state_out_o(state_out), .retire_o(retire), .retire_count_o(retire_count)
    );

    always #5 clk = ~clk;

    // control unit: 0-7 R-type, 8 lw, 9 sw, 10 beq, 11 bne, 12 addi, 13 jump, 14-15 nop
    always_comb begin
        jump = 0; beq = 0; bne = 0; mem_read = 0; mem_write = 0;
        alu_src = 0; reg_dst = 0; mem_to_reg = 0; reg_write = 0; alu_op = 2'b00;
        case (opcode)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin reg_dst = 1; reg_write = 1; end
            4'd8:  begin alu_op = 2'b10; alu_src = 1; mem_read = 1; mem_to_reg = 1; reg_write = 1; end
            4'd9:  begin alu_op = 2'b10; alu_src = 1; mem_write = 1; end
            4'd10: begin alu_op = 2'b01; beq = 1; end
            4'd11: begin alu_op = 2'b01; bne = 1; end
            4'd12: begin alu_op = 2'b10; alu_src = 1; reg_write = 1; end
            4'd13: jump = 1;
            default: ;
        endcase
    end

    typedef struct { logic [31:0] addr; logic [31:0] data; string tag; } sb_t;
    typedef struct { logic [3:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] exp; string name; } vec_t;

    sb_t         exp_q[$];
    logic [15:0] imem [0:1023];
    logic [31:0] dmem [0:63];
    int checks = 0, errors = 0;
    int iwait_cfg = 0, dwait_cfg = 0, icnt = 0, dcnt = 0;
    int dre_cycles = 0, dact_cycles = 0;
    bit unstable = 0;
    logic [31:0] saved_addr, saved_wd;
    logic        saved_we;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // memory responders: wait-state counts configurable, sampled on the falling edge
    always @(negedge clk) begin
        if (!bus.imem_req) begin
            icnt = 0;
            bus.imem_valid = 1'b0;
        end else if (icnt >= iwait_cfg) begin
            bus.imem_valid = 1'b1;
            bus.imem_rdata = imem[bus.imem_addr[10:1]];
        end else begin
            bus.imem_valid = 1'b0;
            icnt++;
        end

        if (!(bus.dmem_re || bus.dmem_we)) begin
            dcnt = 0;
            bus.dmem_ready = 1'b0;
        end else begin
            dact_cycles++;
            if (bus.dmem_re) dre_cycles++;
            if (dcnt == 0) begin
                saved_addr = bus.dmem_addr; saved_wd = bus.dmem_wdata; saved_we = bus.dmem_we;
            end else if (bus.dmem_addr != saved_addr || bus.dmem_wdata != saved_wd || bus.dmem_we != saved_we) begin
                unstable = 1;
            end
            if (dcnt >= dwait_cfg) begin
                bus.dmem_ready = 1'b1;
                bus.dmem_rdata = dmem[bus.dmem_addr[5:0]];
                if (bus.dmem_we) begin
                    dmem[bus.dmem_addr[5:0]] = bus.dmem_wdata;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_store", bus.dmem_addr, 32'hFFFF_FFFF);
                    end else begin
                        sb_t e;
                        e = exp_q.pop_front();
                        chk({"store_addr_", e.tag}, bus.dmem_addr, e.addr);
                        chk({"store_data_", e.tag}, bus.dmem_wdata, e.data);
                    end
                end
            end else begin
                bus.dmem_ready = 1'b0;
            end
            dcnt++;
        end
    end

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rs, input logic [2:0] rt,
                                        input logic [5:0] low);
        return {op, rs, rt, low};
    endfunction

    task automatic start_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        iwait_cfg = 0; dwait_cfg = 0;
        for (int i = 0; i < 1024; i++) imem[i] = NOP;
        for (int i = 0; i < 64; i++) dmem[i] = '0;
    endtask

    task automatic finish_reset();
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic run_instr(output int cyc, output int fc);
        cyc = 1;
        fc  = (state_out == 3'd0) ? 1 : 0;
        while (!retire && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (state_out == 3'd0) fc++;
        end
    endtask

    task automatic run_until_pc(input logic [15:0] target, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(state_out == 3'd0 && pc_out == target) && n < 400);
        chk({"reach_pc_", tag}, {16'h0, pc_out}, {16'h0, target});
    endtask

    task automatic wait_sb(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({"sb_drain_", tag}, exp_q.size(), 0);
    endtask

    task automatic branch_case(input logic [3:0] op, input logic [31:0] dval, input logic [15:0] exp_pc,
                               input string tag);
        int cyc, fc;
        start_reset();
        en = 1'b1;
        imem[0] = enc(4'd8, 3'd0, 3'd1, 6'd1);
        imem[8] = enc(op, 3'd1, 3'd2, 6'h3E);
        dmem[1] = dval;
        finish_reset();
        run_until_pc(16'hE010, tag);
        dact_cycles = 0;
        run_instr(cyc, fc);
        chk({"br_cycles_", tag}, cyc, 3);
        @(negedge clk);
        chk({"br_pc_", tag}, {16'h0, pc_out}, {16'h0, exp_pc});
        chk({"br_dmem_idle_", tag}, dact_cycles, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        int cyc, fc, req_cycles;
        vecs[0]  = '{4'd0, 32'h5,         32'h7,         32'hC,         "add"};
        vecs[1]  = '{4'd0, 32'hFFFF_FFFF, 32'h1,         32'h0,         "add_wrap"};
        vecs[2]  = '{4'd1, 32'h3,         32'h5,         32'hFFFF_FFFE, "sub_neg"};
        vecs[3]  = '{4'd2, 32'h0000_00F0, 32'h1234,      32'hFFFF_FF0F, "inv"};
        vecs[4]  = '{4'd3, 32'h1,         32'h13,        32'h8,         "shl_low4"};
        vecs[5]  = '{4'd4, 32'h8000_0000, 32'h4,         32'h0800_0000, "shr_logical"};
        vecs[6]  = '{4'd5, 32'hF0F0,      32'hFF00,      32'hF000,      "and"};
        vecs[7]  = '{4'd6, 32'hF0F0,      32'h0F00,      32'hFFF0,      "or"};
        vecs[8]  = '{4'd7, 32'hFFFF_FFFF, 32'h1,         32'h1,         "slt_neg"};
        vecs[9]  = '{4'd7, 32'h1,         32'hFFFF_FFFF, 32'h0,         "slt_pos"};
        vecs[10] = '{4'd7, 32'h5,         32'h5,         32'h0,         "slt_eq"};
        vecs[11] = '{4'd4, 32'hF000_0000, 32'h1C,        32'h000F_0000, "shr_12"};

        // en low at FETCH: no fetch request, PC frozen
        start_reset();
        en = 1'b0;
        imem[0] = 16'hD123;
        finish_reset();
        req_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.imem_req) req_cycles++;
        end
        chk("en0_imem_req", req_cycles, 0);
        chk("en0_state", {29'h0, state_out}, 32'd0);
        chk("en0_pc", {16'h0, pc_out}, {16'h0, PCR});
        @(posedge clk); #1;
        en = 1'b1;
        @(negedge clk);
        run_instr(cyc, fc);
        chk("jump_cycles", cyc, 3);
        chk("jump_retire", {31'h0, retire}, 32'd1);
        @(negedge clk);
        chk("jump_pc", {16'h0, pc_out}, 32'h0000_E246);
        chk("jump_retire_count", retire_count, 32'd1);

        // reset during a stalled load abandons it
        start_reset();
        en = 1'b1;
        imem[0] = enc(4'd8, 3'd0, 3'd1, 6'd1);
        dmem[1] = 32'hDEAD_BEEF;
        dwait_cfg = 10;
        finish_reset();
        begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!(state_out == 3'd3 && bus.dmem_re) && n < 50);
            chk("t1_reach_mem", {29'h0, state_out}, 32'd3);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("t1_rst_dmem_re_0", {31'h0, bus.dmem_re}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_rst_dmem_re_1", {31'h0, bus.dmem_re}, 32'd0);
        imem[0] = enc(4'd9, 3'd0, 3'd1, 6'd8);
        dwait_cfg = 0;
        exp_q.push_back('{32'd8, 32'h0, "t1_r1_untouched"});
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t1_state", {29'h0, state_out}, 32'd0);
        chk("t1_pc", {16'h0, pc_out}, {16'h0, PCR});
        chk("t1_retire_count", retire_count, 32'd0);
        wait_sb("t1");

        // R-type timing
        start_reset();
        en = 1'b1;
        imem[0] = enc(4'd8, 3'd0, 3'd1, 6'd1);
        imem[1] = enc(4'd8, 3'd0, 3'd2, 6'd2);
        imem[2] = enc(4'd0, 3'd1, 3'd2, {3'd3, 3'd0});
        imem[3] = enc(4'd9, 3'd0, 3'd3, 6'd8);
        imem[4] = 16'hD004;
        dmem[1] = 32'd5;
        dmem[2] = 32'd7;
        exp_q.push_back('{32'd8, 32'd12, "t2_add"});
        finish_reset();
        run_until_pc(16'hE004, "t2");
        run_instr(cyc, fc);
        chk("t2_add_cycles", cyc, 4);
        @(negedge clk);
        chk("t2_retire_single", {31'h0, retire}, 32'd0);
        chk("t2_pc", {16'h0, pc_out}, 32'h0000_E006);
        chk("t2_retire_count", retire_count, 32'd3);
        wait_sb("t2");

        // wait states on both memories
        start_reset();
        en = 1'b1;
        imem[0] = enc(4'd12, 3'd0, 3'd2, 6'd5);
        imem[1] = enc(4'd8, 3'd0, 3'd1, 6'd1);
        imem[2] = enc(4'd9, 3'd0, 3'd1, 6'd8);
        imem[3] = enc(4'd9, 3'd0, 3'd2, 6'd9);
        imem[4] = 16'hD004;
        dmem[1] = 32'hCAFE_0123;
        iwait_cfg = 2;
        exp_q.push_back('{32'd8, 32'hCAFE_0123, "t3_load"});
        exp_q.push_back('{32'd9, 32'd5, "t3_addi"});
        finish_reset();
        @(negedge clk);
        run_instr(cyc, fc);
        chk("t3_addi_cycles", cyc, 6);
        chk("t3_fetch_hold", fc, 3);
        iwait_cfg = 0;
        dwait_cfg = 3;
        dre_cycles = 0;
        unstable = 0;
        @(negedge clk);
        run_instr(cyc, fc);
        chk("t3_load_cycles", cyc, 8);
        chk("t3_dmem_re_cycles", dre_cycles, 4);
        chk("t3_addr_stable", {31'h0, unstable}, 32'd0);
        dwait_cfg = 0;
        wait_sb("t3");

        // branches at 0xE010 with offset -2
        branch_case(4'd10, 32'h0,         16'hE00E, "beq_taken");
        branch_case(4'd11, 32'h0,         16'hE012, "bne_not_taken");
        branch_case(4'd10, 32'h0001_0000, 16'hE012, "beq_upper_bits");
        branch_case(4'd11, 32'h0001_0000, 16'hE00E, "bne_upper_bits");

        // ALU table: two loads, one R-type op, store the result
        foreach (vecs[k]) begin
            start_reset();
            en = 1'b1;
            imem[0] = enc(4'd8, 3'd0, 3'd1, 6'd1);
            imem[1] = enc(4'd8, 3'd0, 3'd2, 6'd2);
            imem[2] = enc(vecs[k].op, 3'd1, 3'd2, {3'd3, 3'd0});
            imem[3] = enc(4'd9, 3'd0, 3'd3, 6'd8);
            imem[4] = 16'hD004;
            dmem[1] = vecs[k].a;
            dmem[2] = vecs[k].b;
            exp_q.push_back('{32'd8, vecs[k].exp, vecs[k].name});
            finish_reset();
            wait_sb(vecs[k].name);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
